// File: rtl/gates_pkg.sv
// Shared definitions for the gates/ family: serial OR controller state encoding.
package gates_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/or1.sv
// 1-bit OR primitive shared by the parallel and serial OR implementations.
module or1 (
   input  logic a,
   input  logic b,
   output logic y_c
);

   assign y_c = a | b;

endmodule

// File: rtl/or16_serial_ctrl.sv
// Sequencer for or16_serial: IDLE -> SHIFT (WIDTH edges) -> DONE -> IDLE, with registered handshake flags.
module or16_serial_ctrl
   import gates_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   output logic ready,
   output logic busy,
   output logic done
);

   localparam int unsigned CNTW = $clog2(WIDTH);

   state_t            state;
   logic [CNTW-1:0]   count;

   // Flags are registered alongside the state so they change only on clock edges.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         count <= '0;
         ready <= 1'b1;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state <= S_SHIFT;
                  count <= '0;
                  ready <= 1'b0;
                  busy  <= 1'b1;
               end
            end
            S_SHIFT: begin
               count <= count + CNTW'(1);
               if (count == CNTW'(WIDTH - 1)) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               done  <= 1'b0;
               ready <= 1'b1;
            end
            default: begin
               state <= S_IDLE;
               count <= '0;
               ready <= 1'b1;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/or16_serial.sv
// Bit-serial WIDTH-bit bitwise OR, LSB first, one result bit per clock.
module or16_serial
   import gates_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out
);

   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic             bit_c;
   logic             accept_c;

   assign accept_c = start & ready;

   or16_serial_ctrl #(
      .WIDTH (WIDTH)
   ) u_ctrl (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .ready (ready),
      .busy  (busy),
      .done  (done)
   );

   or1 u_or (
      .a   (sa[0]),
      .b   (sb[0]),
      .y_c (bit_c)
   );

   // Operands are captured only on acceptance; results enter from the MSB end.
   always_ff @(posedge clk) begin
      if (reset) begin
         sa  <= '0;
         sb  <= '0;
         out <= '0;
      end else if (accept_c) begin
         sa  <= a;
         sb  <= b;
         out <= '0;
      end else if (busy) begin
         sa  <= sa >> 1;
         sb  <= sb >> 1;
         out <= {bit_c, out[WIDTH-1:1]};
      end
   end

endmodule

// File: tb/tb_or16_serial.sv
// Randomized scoreboard bench for or16_serial against a word-level OR model.
module tb_or16_serial;

   localparam int unsigned WIDTH = 16;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] out;

   typedef struct {
      logic [WIDTH-1:0] expv;
      int               acc;
   } sb_t;

   sb_t              q[$];
   int               cyc = 0;
   int               next_free = 0;
   bit               reset_seen = 0;
   logic [WIDTH-1:0] last_result = '0;
   int               checks = 0;
   int               errors = 0;

   or16_serial #(
      .WIDTH (WIDTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .a     (a),
      .b     (b),
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .out   (out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Reference model: an accepted request yields a|b; the unit is free again WIDTH+2 edges later.
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         if (reset) begin
            q.delete();
            next_free   = cyc + 1;
            last_result = '0;
            reset_seen  = 1;
         end else if (reset_seen && start && cyc >= next_free) begin
            q.push_back('{expv: a | b, acc: cyc});
            next_free = cyc + WIDTH + 2;
         end
      end
   end

   // Monitor: checks handshake flags every cycle and the result on each done pulse.
   initial begin
      forever begin
         @(negedge clk);
         if (reset_seen) begin
            if (q.size() > 0 && cyc <= q[0].acc + WIDTH - 1) begin
               check("busy_phase_busy",  32'(busy),  32'd1);
               check("busy_phase_ready", 32'(ready), 32'd0);
               check("busy_phase_done",  32'(done),  32'd0);
            end else if (q.size() > 0 && cyc == q[0].acc + WIDTH) begin
               check("done_pulse", 32'(done),  32'd1);
               check("done_busy",  32'(busy),  32'd0);
               check("done_ready", 32'(ready), 32'd0);
               check("result",     32'(out),   32'(q[0].expv));
               last_result = q[0].expv;
               void'(q.pop_front());
            end else begin
               check("idle_ready", 32'(ready), 32'd1);
               check("idle_busy",  32'(busy),  32'd0);
               check("idle_done",  32'(done),  32'd0);
               check("idle_out",   32'(out),   32'(last_result));
            end
         end
      end
   end

   task automatic wait_free();
      int g = 0;
      while (cyc + 1 < next_free && g < 200) begin
         @(negedge clk);
         g++;
      end
      if (g >= 200) begin
         checks++;
         errors++;
         $display("FAIL wait_free timeout: got busy expected free");
      end
   endtask

   task automatic churn(input int n);
      repeat (n) begin
         @(negedge clk);
         a = WIDTH'($urandom);
         b = WIDTH'($urandom);
      end
   endtask

   task automatic issue(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb);
      wait_free();
      a     = va;
      b     = vb;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a     = WIDTH'($urandom);
      b     = WIDTH'($urandom);
   endtask

   initial begin
      int g;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      churn(2);

      issue(16'h0001, 16'h0000);
      issue(16'hA5A5, 16'h0F0F);
      issue(16'hFFFF, 16'h0000);
      issue(16'h0000, 16'h0000);

      // Start held high across SHIFT/DONE with operand churn.
      wait_free();
      a     = 16'h1234;
      b     = 16'h8000;
      start = 1'b1;
      churn(WIDTH + 4);
      start = 1'b0;

      // Reset in the middle of an operation aborts it.
      issue(16'hFFFF, 16'h0000);
      repeat (6) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      issue(16'h00F0, 16'h0F00);

      for (int i = 0; i < 20; i++) begin
         issue(WIDTH'($urandom), WIDTH'($urandom));
         churn(int'($urandom_range(0, 20)));
      end

      g = 0;
      while ((q.size() > 0 || cyc < next_free) && g < 200) begin
         @(negedge clk);
         g++;
      end
      if (g >= 200) begin
         checks++;
         errors++;
         $display("FAIL drain timeout: got %0d pending expected 0", q.size());
      end
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/or16_serial.md
Name: or16_serial

Overview:
- Bit-serial, multi-cycle counterpart of the combinational Or16 gate: computes the same WIDTH-bit bitwise OR one bit per clock, LSB first.
- Used where area matters more than latency.
- Sits beside Or16 in gates/; its bench reuses the Or16 vectors so both implementations can be compared word-for-word.
- Handshake: start/busy/done; result held stable until the next accepted start.

Parameters:
- WIDTH, 16, operand and result width in bits; must be ≥2 and a power of two.
- CNTW, $clog2(WIDTH), bit-index counter width; derived, not overridden.

Ports:
- clk  input  1  single clock, rising-edge.
- reset  input  1  synchronous, active-high; sampled on rising clk.
- start  input  1  request; accepted only when ready=1.
- a  input  WIDTH  operand A; sampled only on the accepting edge.
- b  input  WIDTH  operand B; sampled only on the accepting edge.
- ready  output  1  high in IDLE; start is accepted this cycle if asserted.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse; out is valid from this cycle.
- out  output  WIDTH  result register; bit i = a[i] | b[i] of the accepted operands.

Behaviour:
- Reset (reset=1 at a rising edge): state=IDLE, count=0, shift regs=0, out=0, ready=1, busy=0, done=0. Reset has priority over every other input. Reset mid-SHIFT aborts the operation: out=0, no done pulse.
- States:
  - IDLE: ready=1. On start=1, load sa<=a, sb<=b, count<=0, out<=0, and go to SHIFT.
  - SHIFT: busy=1, ready=0. Each edge:
    - out <= {sa[0]|sb[0], out[WIDTH-1:1]} (result shifted in from the MSB).
    - sa<=sa>>1, sb<=sb>>1, count<=count+1.
    - When count==WIDTH-1 on this edge, go to DONE.
    - Exactly WIDTH edges are spent in SHIFT.
  - DONE: done=1 for exactly one cycle; always go to IDLE next. start in DONE is ignored and not queued.
- Latency: start accepted at edge k gives done=1 during the cycle after edge k+WIDTH, i.e. WIDTH+1 edges from acceptance to the done cycle. Back-to-back issue interval is WIDTH+2 cycles.
- start while busy or in DONE: ignored. Operands and out are unaffected.
- a/b changing after acceptance: no effect on the result.
- out holds its value through DONE and IDLE. It is cleared only by an accepted start or by reset.
- Counter wrap: count is CNTW bits. The terminal compare is at WIDTH-1, so count never wraps during valid operation.
- Outputs ready/busy/done are decoded from state. No combinational path from a, b or start to any output.
- X on a/b when start=0 must not propagate into state.

Decomposition:
- Shared package gates_pkg: state encoding constants S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2.
- One sub-module is natural: or16_serial_ctrl (state register, bit counter, ready/busy/done decode).
- The datapath (sa/sb/out shift registers and the 1-bit OR) stays in the top. The 1-bit OR instantiates the existing 1-bit Or gate, so the serial and parallel paths share the primitive.

Test Plan:
- Reset then idle: hold reset 2 cycles, release -> ready=1, busy=0, done=0, out=16'h0000.
- Basic op: a=16'h0001, b=16'h0000, start for 1 cycle -> busy high 16 cycles; done pulse on the 17th cycle after acceptance; out=16'h0001; matches Or16.
- Mixed bits: a=16'hA5A5, b=16'h0F0F -> out=16'hAFAF.
- Extremes: a=16'hFFFF, b=16'h0000 -> out=16'hFFFF. Then a=b=16'h0000 -> out=16'h0000 (out is cleared on accept, not stale).
- Ignored start and operand churn: start=1 continuously from acceptance of a=16'h1234, b=16'h8000. Toggle a/b randomly during SHIFT -> one result 16'h9234, done pulses once; the next accept happens in the IDLE cycle after DONE.
- Reset mid-op: accept a=16'hFFFF, b=0; assert reset after 7 SHIFT cycles -> next cycle state IDLE, out=16'h0000, no done pulse. Then run 16'h00F0|16'h0F00 -> out=16'h0FF0.
